// File: rtl/sat_round_fp_pipe_pkg.sv
// Shared constants for the saturating/rounding fixed-point pipeline.
package sat_round_fp_pipe_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'b00,
    RND_HALF_UP   = 2'b01,
    RND_CONV      = 2'b10,
    RND_TRUNC_ALT = 2'b11
  } rnd_mode_e;

endpackage

// File: rtl/sat_round_fp_lane.sv
// One channel of the datapath: requantise S(NB_XI,NBF_XI) to S(NB_XO,NBF_XO)
// with selectable rounding, then saturate or wrap into the output range.
module sat_round_fp_lane
  import sat_round_fp_pipe_pkg::*;
#(
  parameter int NB_XI  = 20,
  parameter int NBF_XI = 12,
  parameter int NB_XO  = 8,
  parameter int NBF_XO = 6
) (
  input  logic signed [NB_XI-1:0] i_x,
  input  logic        [1:0]       i_rnd_mode,
  input  logic                    i_sat_en,
  output logic signed [NB_XO-1:0] o_y,
  output logic                    o_ovf
);

  localparam int D  = (NBF_XI > NBF_XO) ? NBF_XI - NBF_XO : 0;
  localparam int SH = (NBF_XO > NBF_XI) ? NBF_XO - NBF_XI : 0;
  localparam int EW = NB_XI + 1;
  localparam int RW = EW + SH;
  localparam int CW = ((RW > NB_XO) ? RW : NB_XO) + 1;

  localparam logic signed [EW-1:0] HALF = (D > 0) ? EW'(1 <<< ((D > 0) ? D - 1 : 0)) : '0;
  localparam logic signed [EW-1:0] MASK = EW'((1 <<< D) - 1);
  localparam logic signed [CW-1:0] MAXC = CW'((64'sd1 <<< (NB_XO - 1)) - 64'sd1);
  localparam logic signed [CW-1:0] MINC = -MAXC - CW'(1);
  localparam logic signed [NB_XO-1:0] MAXO = {1'b0, {(NB_XO-1){1'b1}}};
  localparam logic signed [NB_XO-1:0] MINO = {1'b1, {(NB_XO-1){1'b0}}};

  // One guard bit above the input keeps the rounding carry from wrapping.
  function automatic logic signed [RW-1:0] round_fn(input logic signed [NB_XI-1:0] x,
                                                     input logic [1:0] mode);
    logic signed [EW-1:0] ext, off, sum;
    ext = EW'(x);
    off = '0;
    if (mode == RND_HALF_UP) begin
      off = HALF;
    end else if (mode == RND_CONV) begin
      if (!(((ext & MASK) == HALF) && !ext[D])) off = HALF;
    end
    sum = ext + off;
    return RW'(sum >>> D) <<< SH;
  endfunction

  function automatic logic [NB_XO:0] range_fn(input logic signed [RW-1:0] r,
                                              input logic sat);
    logic signed [CW-1:0] c;
    logic                 hi, lo;
    logic [NB_XO-1:0]     y;
    c  = CW'(r);
    hi = c > MAXC;
    lo = c < MINC;
    y  = c[NB_XO-1:0];
    if (sat && hi) y = MAXO;
    if (sat && lo) y = MINO;
    return {hi | lo, y};
  endfunction

  logic [NB_XO:0] res;

  always_comb begin
    res   = range_fn(round_fn(i_x, i_rnd_mode), i_sat_en);
    o_ovf = res[NB_XO];
    o_y   = res[NB_XO-1:0];
  end

endmodule

// File: rtl/sat_round_fp_pipe.sv
// Two-stage valid/ready pipeline around N_CH requantisation lanes, with a
// sticky overflow flag and a saturating count of overflowed output transfers.
module sat_round_fp_pipe
  import sat_round_fp_pipe_pkg::*;
#(
  parameter int NB_XI  = 20,
  parameter int NBF_XI = 12,
  parameter int NB_XO  = 8,
  parameter int NBF_XO = 6,
  parameter int N_CH   = 2,
  parameter int NB_CNT = 16
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [N_CH*NB_XI-1:0]   i_data,
  input  logic [1:0]              i_rnd_mode,
  input  logic                    i_sat_en,
  input  logic                    i_clr,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [N_CH*NB_XO-1:0]   o_data,
  output logic [N_CH-1:0]         o_ovf,
  output logic                    o_ovf_sticky,
  output logic [NB_CNT-1:0]       o_ovf_cnt
);

  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [N_CH*NB_XI-1:0] s1_data_q;
  logic [1:0]            s1_mode_q;
  logic                  s1_sat_q;
  logic [N_CH*NB_XO-1:0] s2_data_q, lane_data;
  logic [N_CH-1:0]       s2_ovf_q, lane_ovf;
  logic                  sticky_q, sticky_d;
  logic [NB_CNT-1:0]     cnt_q, cnt_d;
  logic                  s2_free, in_xfer, out_xfer;

  assign s2_free  = !s2_valid_q || i_ready;
  assign o_ready  = !s1_valid_q || s2_free;
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = s2_valid_q && i_ready;

  always_comb begin
    s1_valid_d = o_ready ? i_valid : s1_valid_q;
    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    if (i_clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (out_xfer && |s2_ovf_q) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  // Stage 1: capture sample with its rounding mode and saturate enable.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_data_q <= i_data;
      s1_mode_q <= i_rnd_mode;
      s1_sat_q  <= i_sat_en;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    sat_round_fp_lane #(
      .NB_XI  (NB_XI),
      .NBF_XI (NBF_XI),
      .NB_XO  (NB_XO),
      .NBF_XO (NBF_XO)
    ) u_lane (
      .i_x        (s1_data_q[k*NB_XI +: NB_XI]),
      .i_rnd_mode (s1_mode_q),
      .i_sat_en   (s1_sat_q),
      .o_y        (lane_data[k*NB_XO +: NB_XO]),
      .o_ovf      (lane_ovf[k])
    );
  end

  // Stage 2: result register; holds while downstream stalls.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      if (s1_valid_q && s2_free) begin
        s2_data_q <= lane_data;
        s2_ovf_q  <= lane_ovf;
      end
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_data       = s2_data_q;
  assign o_ovf        = s2_ovf_q;
  assign o_ovf_sticky = sticky_q;
  assign o_ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_sat_round_fp_pipe.sv
// Self-checking bench: directed vectors, randomised streams with backpressure
// against an arithmetic reference model, counter saturation/clear and reset.
module tb_sat_round_fp_pipe;

  localparam int NB_XI  = 20;
  localparam int NBF_XI = 12;
  localparam int NB_XO  = 8;
  localparam int NBF_XO = 6;
  localparam int N_CH   = 2;
  localparam int NB_CNT = 6;
  localparam int D      = NBF_XI - NBF_XO;
  localparam int CNT_MAX = (1 << NB_CNT) - 1;

  logic                  clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic                  i_valid = 1'b0;
  logic                  o_ready;
  logic [N_CH*NB_XI-1:0] i_data = '0;
  logic [1:0]            i_rnd_mode = 2'b00;
  logic                  i_sat_en = 1'b1;
  logic                  i_clr = 1'b0;
  logic                  o_valid;
  logic                  i_ready = 1'b1;
  logic [N_CH*NB_XO-1:0] o_data;
  logic [N_CH-1:0]       o_ovf;
  logic                  o_ovf_sticky;
  logic [NB_CNT-1:0]     o_ovf_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sat_round_fp_pipe #(
    .NB_XI (NB_XI), .NBF_XI (NBF_XI), .NB_XO (NB_XO), .NBF_XO (NBF_XO),
    .N_CH (N_CH), .NB_CNT (NB_CNT)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_rnd_mode   (i_rnd_mode),
    .i_sat_en     (i_sat_en),
    .i_clr        (i_clr),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_ovf        (o_ovf),
    .o_ovf_sticky (o_ovf_sticky),
    .o_ovf_cnt    (o_ovf_cnt)
  );

  // Reference: value / 2^D with floor/half-up/half-even rounding, then range.
  function automatic logic [NB_XO:0] ref_lane(input logic [NB_XI-1:0] xr,
                                              input logic [1:0] mode, input logic sat);
    longint v, sc, r, q, hi, lo;
    logic ovf;
    logic [NB_XO-1:0] y;
    v  = longint'($signed(xr));
    sc = longint'(1) << D;
    r  = ((v % sc) + sc) % sc;
    q  = (v - r) / sc;
    if (mode == 2'b01 && 2 * r >= sc) q = q + 1;
    if (mode == 2'b10 && (2 * r > sc || (2 * r == sc && (q % 2) != 0))) q = q + 1;
    hi  = (longint'(1) << (NB_XO - 1)) - 1;
    lo  = -hi - 1;
    ovf = (q > hi) || (q < lo);
    if (ovf && sat) q = (q > hi) ? hi : lo;
    y = NB_XO'(q);
    return {ovf, y};
  endfunction

  function automatic logic [NB_XI-1:0] rand_x();
    int s;
    case ($urandom_range(0, 2))
      0: return NB_XI'($urandom);
      1: begin s = int'($urandom_range(0, 32767)) - 16384; return NB_XI'(s); end
      default: begin s = int'($urandom_range(0, 511)) - 256; return NB_XI'(s * 32); end
    endcase
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_ovf !== '0 || o_ovf_sticky !== 1'b0 || o_ovf_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h ovf=%b sticky=%b cnt=%0d, required all zero",
               o_valid, o_data, o_ovf, o_ovf_sticky, o_ovf_cnt);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_directed();
    logic [NB_XI-1:0] vx [11] = '{20'h01800, 20'h03000, 20'hFD000, 20'h03000, 20'h00820,
                                 20'h00820, 20'h00820, 20'h00860, 20'h01FE0, 20'h00820, 20'hFF7E0};
    logic [1:0]       vm [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd2};
    logic             vs [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]       vy [11] = '{8'h60, 8'h7F, 8'h80, 8'hC0, 8'h20, 8'h21, 8'h20, 8'h22, 8'h7F, 8'h20, 8'hE0};
    logic             vo [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    i_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      i_data = {20'h00000, vx[i]};
      i_rnd_mode = vm[i];
      i_sat_en = vs[i];
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_rnd_mode = 2'b00;
      i_sat_en = ~vs[i];
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early_%0d: valid=%b one cycle after transfer, required 0", i, o_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_data !== {8'h00, vy[i]} || o_ovf !== {1'b0, vo[i]}) begin
        errors++;
        $display("FAIL directed_%0d: x=%h valid=%b data=%h ovf=%b, required valid=1 data=%h ovf=%b",
                 i, vx[i], o_valid, o_data, o_ovf, {8'h00, vy[i]}, {1'b0, vo[i]});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream(input string name, input int n, input bit toggle_rdy);
    logic [17:0]      exp_q[$];
    logic [17:0]      e, held;
    logic [NB_XO:0]   m0, m1;
    logic [NB_XI-1:0] x0, x1;
    bit               holding;
    int               sent, got, n_ovf, exp_cnt;
    sent = 0; got = 0; n_ovf = 0; holding = 0; held = '0; x0 = '0; x1 = '0;
    i_clr = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    for (int cyc = 0; cyc < 4000 && got < n; cyc++) begin
      if (sent < n && (toggle_rdy || $urandom_range(0, 3) != 0)) begin
        x0 = rand_x(); x1 = rand_x();
        i_data = {x1, x0};
        i_rnd_mode = 2'($urandom_range(0, 3));
        i_sat_en = 1'($urandom_range(0, 1));
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      i_ready = toggle_rdy ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (holding) begin
        checks++;
        if (o_valid !== 1'b1 || {o_ovf, o_data} !== held) begin
          errors++;
          $display("FAIL %s_stall_hold: valid=%b ovf_data=%h, required valid=1 ovf_data=%h",
                   name, o_valid, {o_ovf, o_data}, held);
        end
      end
      holding = o_valid && !i_ready;
      held = {o_ovf, o_data};
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_spurious: output ovf_data=%h with no sample outstanding", name, {o_ovf, o_data});
        end else begin
          e = exp_q.pop_front();
          if (e[17:16] != 2'b00) n_ovf++;
          if ({o_ovf, o_data} !== e) begin
            errors++;
            $display("FAIL %s_out_%0d: ovf_data=%h, required %h", name, got, {o_ovf, o_data}, e);
          end
        end
        got++;
      end
      if (i_valid && o_ready) begin
        m0 = ref_lane(x0, i_rnd_mode, i_sat_en);
        m1 = ref_lane(x1, i_rnd_mode, i_sat_en);
        exp_q.push_back({m1[NB_XO], m0[NB_XO], m1[NB_XO-1:0], m0[NB_XO-1:0]});
        sent++;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_count: outputs=%0d, required %0d within cycle budget", name, got, n);
    end
    exp_cnt = (n_ovf > CNT_MAX) ? CNT_MAX : n_ovf;
    checks++;
    if (o_ovf_cnt !== NB_CNT'(exp_cnt) || o_ovf_sticky !== (n_ovf != 0)) begin
      errors++;
      $display("FAIL %s_ovf_cnt: cnt=%0d sticky=%b, required cnt=%0d sticky=%b",
               name, o_ovf_cnt, o_ovf_sticky, exp_cnt, n_ovf != 0);
    end
  endtask

  task automatic test_counter();
    i_clr = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    i_data = {20'h00000, 20'h01800}; i_rnd_mode = 2'b00; i_sat_en = 1'b1;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (o_ovf_cnt !== '0 || o_ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL cnt_no_ovf: cnt=%0d sticky=%b, required 0 0", o_ovf_cnt, o_ovf_sticky);
    end
    i_data = {20'h00000, 20'h03000};
    i_valid = 1'b1;
    repeat (CNT_MAX + 7) @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (o_ovf_cnt !== NB_CNT'(CNT_MAX) || o_ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%0d sticky=%b, required %0d 1", o_ovf_cnt, o_ovf_sticky, CNT_MAX);
    end
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    i_clr = 1'b1;
    checks++;
    if (o_valid !== 1'b1 || o_ovf !== 2'b01) begin
      errors++;
      $display("FAIL clr_setup: valid=%b ovf=%b, required valid=1 ovf=01", o_valid, o_ovf);
    end
    @(posedge clk); #1;
    i_clr = 1'b0;
    checks++;
    if (o_ovf_cnt !== '0 || o_ovf_sticky !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: cnt=%0d sticky=%b valid=%b, required 0 0 0", o_ovf_cnt, o_ovf_sticky, o_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    i_ready = 1'b1; i_rnd_mode = 2'b00; i_sat_en = 1'b1;
    i_data = {20'h03000, 20'h03000};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_data = {20'hFD000, 20'h00820};
    @(posedge clk); #1;
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_ovf !== '0 || o_ovf_cnt !== '0 || o_ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b data=%h ovf=%b cnt=%0d sticky=%b, required all zero",
               o_valid, o_data, o_ovf, o_ovf_cnt, o_ovf_sticky);
    end
    @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_flush: stale output valid seen=1 after reset, required 0");
    end
    i_data = {20'hFD000, 20'h01800};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h8060 || o_ovf !== 2'b10) begin
      errors++;
      $display("FAIL midreset_first: valid=%b data=%h ovf=%b, required 1 8060 10", o_valid, o_data, o_ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream("back_to_back", 8, 1'b1);
    test_stream("random", 150, 1'b0);
    test_counter();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
